// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Entry layout is {blank, dp, hex[3:0]}; segment codes are active-low g..a.
package seg_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } entry_t;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  // Index 15 first, so SEG_CODE[h] is the pattern for hex digit h.
  localparam logic [15:0][6:0] SEG_CODE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam entry_t     BLANK_ENTRY = 6'b100000;
  localparam logic [7:0] SEG_OFF     = 8'hFF;

  function automatic logic [7:0] seg_of(entry_t e);
    logic [7:0] v;
    v = SEG_OFF;
    if (!e.blank) begin
      v = {~e.dp, SEG_CODE[e.hex]};
    end
    return v;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational entry -> active-low segment byte (bit7 = dp).
// Shared with the future dot-array path.
module seg_decode
  import seg_pkg::*;
(
  input  logic [5:0] i_entry,
  output logic [7:0] o_seg
);

  entry_t w_entry;

  assign w_entry = entry_t'(i_entry);
  assign o_seg   = seg_of(w_entry);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit scan controller with shadow/active buffers and tear-free commit.
// Optional SEG_DIM_EN adds a 3-bit brightness input that trims SHOW drive.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DWELL    = 8192,
  parameter int BLANK    = 256
)(
`ifdef SEG_DIM_EN
  input  logic [2:0] bright,
`endif
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic       commit,
  output logic [7:0] dataout,
  output logic [2:0] U2_138,
  output logic       U2_138_select,
  output logic       U3_138_select,
  output logic       frame_tick
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [2:0]    DIG_LAST   = 3'(N_DIGITS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_digit;
  logic [2:0]      w_digit_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            r_pending;
  entry_t          r_shadow [8];
  entry_t          r_active [8];

  logic [7:0]      r_dataout;
  logic [2:0]      r_u2;
  logic            r_sel;
  logic            r_tick;

  logic            w_wr_fire;
  logic            w_cm_fire;
  logic            w_addr_ok;
  logic            w_frame_end;
  logic            w_tick_nxt;
  logic            w_drive;
  logic [7:0]      w_seg;

`ifdef SEG_DIM_EN
  logic [2:0]      r_bright;
  logic [2:0]      w_bright_nxt;
  int              w_on_cycles;
`endif

  assign w_addr_ok = {1'b0, wr_addr} < 4'(N_DIGITS);
  assign w_wr_fire = wr_valid & ~r_pending;
  assign w_cm_fire = commit & ~r_pending;

  assign w_frame_end = (r_state == S_SHOW)
                    && (r_digit == DIG_LAST)
                    && (r_cnt == DWELL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_cnt_nxt   = r_cnt + 1'b1;
`ifdef SEG_DIM_EN
    w_bright_nxt = r_bright;
`endif
    unique case (r_state)
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
`ifdef SEG_DIM_EN
          w_bright_nxt = bright;
`endif
        end
      end
      S_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_digit_nxt = (r_digit == DIG_LAST) ? 3'd0
                                              : r_digit + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BLANK;
      r_digit <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef SEG_DIM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bright <= 3'd7;
    end else begin
      r_bright <= w_bright_nxt;
    end
  end

  always_comb begin
    w_on_cycles = ((int'(w_bright_nxt) + 1) * DWELL) / 8;
  end

  assign w_drive = (w_state_nxt == S_SHOW)
                && (int'(w_cnt_nxt) < w_on_cycles);
`else
  assign w_drive = (w_state_nxt == S_SHOW);
`endif

  // Copy happens on the frame's last SHOW cycle; writes are frozen while pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= BLANK_ENTRY;
        r_active[i] <= BLANK_ENTRY;
      end
    end else begin
      if (w_wr_fire && w_addr_ok) begin
        r_shadow[wr_addr] <= entry_t'(wr_data);
      end
      if (w_frame_end && r_pending) begin
        r_pending <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end else if (w_cm_fire) begin
        r_pending <= 1'b1;
      end
    end
  end

  seg_decode u_dec (
    .i_entry (r_active[w_digit_nxt]),
    .o_seg   (w_seg)
  );

  assign w_tick_nxt = (w_state_nxt == S_SHOW)
                   && (w_digit_nxt == DIG_LAST)
                   && (w_cnt_nxt == DWELL_LAST);

  // Outputs are built from the next state so pins change exactly with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dataout <= SEG_OFF;
      r_u2      <= 3'd0;
      r_sel     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_dataout <= w_drive ? w_seg : SEG_OFF;
      r_u2      <= w_digit_nxt;
      r_sel     <= w_drive;
      r_tick    <= w_tick_nxt;
    end
  end

  assign dataout       = r_dataout;
  assign U2_138        = r_u2;
  assign U2_138_select = r_sel;
  assign U3_138_select = 1'b0;
  assign frame_tick    = r_tick;
  assign wr_ready      = ~r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a time-indexed frame model.
// Builds with or without SEG_DIM_EN.
module tb_seg_scan_ctrl;

  localparam int ND  = 8;
  localparam int DW  = 16;
  localparam int BL  = 4;
  localparam int PER = DW + BL;
  localparam int FR  = ND * PER;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       commit = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [5:0] wr_data = 6'd0;
  logic       wr_ready;
  logic [7:0] dataout;
  logic [2:0] U2_138;
  logic       U2_138_select;
  logic       U3_138_select;
  logic       frame_tick;
`ifdef SEG_DIM_EN
  logic [2:0] bright = 3'd7;
`endif

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .N_DIGITS (ND),
    .DWELL    (DW),
    .BLANK    (BL)
  ) dut (
`ifdef SEG_DIM_EN
    .bright        (bright),
`endif
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .dataout       (dataout),
    .U2_138        (U2_138),
    .U2_138_select (U2_138_select),
    .U3_138_select (U3_138_select),
    .frame_tick    (frame_tick)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int         m_t;
  bit         m_pend;
  logic [5:0] m_sh  [8];
  logic [5:0] m_act [8];
  int         m_br;

  logic [7:0] HEXSEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, m_t);
    end
  endtask

  function automatic logic [7:0] m_dec(logic [5:0] e);
    logic [7:0] s;
    if (e[5]) return 8'hFF;
    s = HEXSEG[e[3:0]];
    s[7] = ~e[4];
    return s;
  endfunction

  task automatic m_reset();
    m_t    = 0;
    m_pend = 1'b0;
    m_br   = 7;
    for (int i = 0; i < 8; i++) begin
      m_sh[i]  = 6'b100000;
      m_act[i] = 6'b100000;
    end
  endtask

  task automatic m_edge();
    int pos;
    if (rst) begin
      m_reset();
    end else begin
      pos = m_t % FR;
      if (m_pend && pos == FR - 1) begin
        for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
        m_pend = 1'b0;
      end else if (!m_pend) begin
        if (wr_valid && int'(wr_addr) < ND) m_sh[wr_addr] = wr_data;
        if (commit) m_pend = 1'b1;
      end
`ifdef SEG_DIM_EN
      if (pos % PER == BL - 1) m_br = int'(bright);
`endif
      m_t++;
    end
  endtask

  task automatic m_check();
    int pos, dig, ph;
    bit drv;
    pos = m_t % FR;
    dig = pos / PER;
    ph  = pos % PER;
    drv = (ph >= BL);
`ifdef SEG_DIM_EN
    drv = drv && ((ph - BL) < ((m_br + 1) * DW) / 8);
`endif
    check("dataout", 32'(dataout),
          32'(drv ? m_dec(m_act[dig]) : 8'hFF));
    check("select", 32'(U2_138_select), 32'(drv));
    check("digit", 32'(U2_138), 32'(dig));
    check("tick", 32'(frame_tick), 32'(pos == FR - 1));
    check("ready", 32'(wr_ready), 32'(!m_pend));
    check("u3sel", 32'(U3_138_select), 32'd0);
  endtask

  task automatic step(bit v, logic [2:0] a, logic [5:0] d, bit c);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    commit   = c;
    @(posedge clk);
    m_edge();
    #1;
    m_check();
    @(negedge clk);
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 6'd0, 1'b0);
  endtask

  task automatic run_to(int pos);
    for (int i = 0; i < FR && (m_t % FR) != pos; i++) begin
      step(1'b0, 3'd0, 6'd0, 1'b0);
    end
  endtask

  initial begin
    m_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataout", 32'(dataout), 32'hFF);
    check("rst_digit", 32'(U2_138), 32'd0);
    check("rst_select", 32'(U2_138_select), 32'd0);
    check("rst_u3sel", 32'(U3_138_select), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    idle(3 * FR);

    run_to(50);
    step(1'b1, 3'd3, 6'h05, 1'b0);
    step(1'b0, 3'd0, 6'h00, 1'b1);
    idle(10);
    step(1'b1, 3'd1, 6'h01, 1'b0);
    step(1'b1, 3'd1, 6'h01, 1'b1);
    idle(2 * FR);

    run_to(30);
    step(1'b1, 3'd0, 6'h18, 1'b1);
    idle(2 * FR);

`ifdef SEG_DIM_EN
    bright = 3'd1;
    idle(FR);
    bright = 3'd7;
    idle(FR);
`endif

    for (int i = 0; i < 2000; i++) begin
`ifdef SEG_DIM_EN
      if ($urandom_range(0, 15) == 0) bright = 3'($urandom);
`endif
      step($urandom_range(0, 3) == 0, 3'($urandom), 6'($urandom),
           $urandom_range(0, 40) == 0);
    end

    idle(2 * FR);
    step(1'b1, 3'd5, 6'h0A, 1'b1);
    idle(FR);
    run_to(5 * PER + BL + 3);
    rst = 1'b1;
    step(1'b0, 3'd0, 6'd0, 1'b0);
    rst = 1'b0;
    idle(FR + 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
